// File: rtl/p4_pkg.sv
// Shared constants, types and helpers for the p4_adder sparse-tree adder.
package p4_pkg;

  // Width of one carry-select block; the tree delivers one carry per block.
  localparam int BLOCK_BITS = 4;

  // Generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of radix-2 prefix levels needed to span nbits positions.
  function automatic int tree_depth(input int nbits);
    return $clog2(nbits);
  endfunction

  // Prefix operator: combine a higher-order span with the adjacent lower one.
  function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/p4_carry_gen.sv
// Sparse-tree carry generator: radix-2 prefix tree over all bit positions,
// tapped only at the block boundaries (bits 4k-1) to produce C4..C_NBITS.
// carries[0] is the raw carry-in.
module p4_carry_gen
  import p4_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0]            a,
  input  logic [NBITS-1:0]            b,
  input  logic                        cin,
  output logic [NBITS/BLOCK_BITS:0]   carries
);

  localparam int DEPTH = tree_depth(NBITS);
  localparam int NBLK  = NBITS / BLOCK_BITS;

  gp_t node   [NBITS];
  gp_t node_n [NBITS];

  // Bit-level g/p with cin folded into position 0, then log2(NBITS) prefix levels.
  always_comb begin
    for (int i = 0; i < NBITS; i++) begin
      node[i].g = a[i] & b[i];
      node[i].p = a[i] ^ b[i];
    end
    node[0].g = node[0].g | (node[0].p & cin);
    for (int i = 0; i < NBITS; i++) begin
      node_n[i] = node[i];
    end

    for (int l = 0; l < DEPTH; l++) begin
      for (int i = 0; i < NBITS; i++) begin
        if (i >= (1 << l)) begin
          node_n[i] = gp_merge(node[i], node[i - (1 << l)]);
        end else begin
          node_n[i] = node[i];
        end
      end
      for (int i = 0; i < NBITS; i++) begin
        node[i] = node_n[i];
      end
    end

    carries    = '0;
    carries[0] = cin;
    for (int k = 1; k <= NBLK; k++) begin
      carries[k] = node[k * BLOCK_BITS - 1].g;
    end
  end

endmodule

// File: rtl/p4_adder.sv
// Pentium-4-style sparse-tree adder with registered outputs (1-cycle latency).
// Optional macro P4_OVERFLOW_EN adds a registered signed-overflow flag ovf.
module p4_adder
  import p4_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  output logic [NBITS-1:0] sum,
  output logic             cout
`ifdef P4_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = NBITS / BLOCK_BITS;

  if ((NBITS % BLOCK_BITS) != 0 || NBITS < 8) begin : g_bad_width
    $error("p4_adder: NBITS must be a multiple of 4 and at least 8");
  end

  logic [NBLK:0]      carries;
  logic [NBITS-1:0]   sum_nxt;
  logic               cout_nxt;
  logic [BLOCK_BITS-1:0] blk_s0;
  logic [BLOCK_BITS-1:0] blk_s1;

  p4_carry_gen #(.NBITS(NBITS)) u_carry_gen (
    .a       (a),
    .b       (b),
    .cin     (cin),
    .carries (carries)
  );

  // Carry-select sum: each block precomputes both carry-in cases, tree carry picks one.
  always_comb begin
    sum_nxt = '0;
    blk_s0  = '0;
    blk_s1  = '0;
    for (int k = 0; k < NBLK; k++) begin
      blk_s0 = a[k*BLOCK_BITS +: BLOCK_BITS] + b[k*BLOCK_BITS +: BLOCK_BITS];
      blk_s1 = a[k*BLOCK_BITS +: BLOCK_BITS] + b[k*BLOCK_BITS +: BLOCK_BITS]
               + {{(BLOCK_BITS-1){1'b0}}, 1'b1};
      sum_nxt[k*BLOCK_BITS +: BLOCK_BITS] = carries[k] ? blk_s1 : blk_s0;
    end
    cout_nxt = carries[NBLK];
  end

`ifdef P4_OVERFLOW_EN
  logic ovf_nxt;

  // Carry into the MSB is recovered from the MSB sum bit: c = s ^ a ^ b.
  always_comb begin
    ovf_nxt = carries[NBLK] ^ (sum_nxt[NBITS-1] ^ a[NBITS-1] ^ b[NBITS-1]);
  end

  // Overflow flag registered alongside the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
    end
  end
`endif

  // Output registers; reset clears any in-flight result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_nxt;
      cout <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_p4_adder.sv
// Scoreboard bench for p4_adder: driver pushes expected results, a falling-edge
// monitor pops and compares. Build with +define+P4_OVERFLOW_EN to cover ovf.
module tb_p4_adder;

  localparam int NBITS = 32;

  typedef struct {
    logic [NBITS-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBITS-1:0] a   = '0;
  logic [NBITS-1:0] b   = '0;
  logic             cin = 1'b0;
  logic [NBITS-1:0] sum;
  logic             cout;
`ifdef P4_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  p4_adder #(.NBITS(NBITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
`ifdef P4_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: plain wide arithmetic and sign rules.
  function automatic exp_t model(input logic [NBITS-1:0] x, input logic [NBITS-1:0] y,
                                 input logic ci);
    exp_t e;
    logic [NBITS:0] full;
    full = {1'b0, x} + {1'b0, y} + {{NBITS{1'b0}}, ci};
    e.s = full[NBITS-1:0];
    e.c = full[NBITS];
    e.o = (x[NBITS-1] == y[NBITS-1]) && (e.s[NBITS-1] != x[NBITS-1]);
    return e;
  endfunction

  // Issue one operation just after a falling edge; it is sampled at the next rising edge.
  task automatic issue(input logic [NBITS-1:0] x, input logic [NBITS-1:0] y, input logic ci);
    @(negedge clk);
    #1;
    a   = x;
    b   = y;
    cin = ci;
    exp_q.push_back(model(x, y, ci));
  endtask

  // Monitor: every falling edge with a pending expectation compares the registered result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum", {32'b0, sum}, {32'b0, e.s});
        check("cout", {63'b0, cout}, {63'b0, e.c});
`ifdef P4_OVERFLOW_EN
        check("ovf", {63'b0, ovf}, {63'b0, e.o});
`endif
      end
    end
  end

  initial begin
    logic [NBITS-1:0] x, y;
    int wait_cnt;

    // Reset state while rst held from time zero.
    #3;
    check("reset_sum", {32'b0, sum}, 64'd0);
    check("reset_cout", {63'b0, cout}, 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Directed cases.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(32'h0000_000F, 32'h0000_0001, 1'b0);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(32'h0FFF_FFFF, 32'h0000_0000, 1'b1);

    // Asynchronous reset mid-cycle discards the in-flight result.
    issue(32'h1234_5678, 32'h1111_1111, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_sum", {32'b0, sum}, 64'd0);
    check("async_rst_cout", {63'b0, cout}, 64'd0);
    @(negedge clk);
    #1;
    a = 32'hDEAD_BEEF;
    b = 32'h0000_0001;
    @(negedge clk);
    check("rst_hold_sum", {32'b0, sum}, 64'd0);
    #1 rst = 1'b0;
    a   = 32'h1234_5678;
    b   = 32'h0000_0008;
    cin = 1'b0;
    exp_q.push_back(model(32'h1234_5678, 32'h0000_0008, 1'b0));

    // Inputs changing between edges must not disturb the held result.
    @(negedge clk);
    #1;
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    cin = 1'b1;
    #2;
    check("hold_between_edges", {32'b0, sum}, {32'b0, 32'h1234_5680});
    exp_q.push_back(model(32'hAAAA_AAAA, 32'h5555_5555, 1'b1));

    // Randomized back-to-back pipeline, with some corner-biased operands.
    for (int i = 0; i < 10000; i++) begin
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: x = '1;
        1: y = ~x;
        2: begin x = 32'h7FFF_FFFF; y = $urandom_range(0, 3); end
        default: ;
      endcase
      issue(x, y, 1'($urandom_range(0, 1)));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    #1;
    check("drain_timeout", {32'b0, 32'(exp_q.size())}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
